// File: rtl/serial_adder_seq.sv
// rtl/serial_adder_seq.sv - bit-serial adder sequencer around a single full-adder cell
//
// Purpose:
//   Adds two WIDTH-bit operands plus a carry-in one bit per clock, LSB first,
//   through one full-adder cell, then presents {carry, sum} with a one-cycle
//   done pulse. Trades latency (WIDTH cycles) for a minimal datapath.
//
// Optional feature (macro SERIAL_ADDER_SUB_EN):
//   Adds input 'sub'. When sub=1 at acceptance, operand B is inverted and the
//   carry flop is preset to 1 (two's-complement subtract). Then c is ignored,
//   sum = num_1 - num_2 mod 2^WIDTH, and carry=1 means no borrow.
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request an operation (accepted in IDLE or DONE)
//   num_1  in   WIDTH  operand A, captured on acceptance
//   num_2  in   WIDTH  operand B, captured on acceptance
//   c      in   1      carry-in, captured on acceptance
//   sub    in   1      subtract select (only with SERIAL_ADDER_SUB_EN)
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse, sum/carry valid
//   sum    out  WIDTH  result of the last completed operation
//   carry  out  1      carry-out of the last completed operation

module serial_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] num_1,
  input  logic [WIDTH-1:0] num_2,
  input  logic             c,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry_ff;
  logic [CW-1:0]    cnt;

  logic             load;
  logic             step;
  logic             last;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] res_next;

  serial_full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry_ff),
    .s  (fa_s),
    .co (fa_co)
  );

  // The counter holds the index of the bit being processed this cycle.
  assign last     = (cnt == CW'(WIDTH - 1));
  assign res_next = {fa_s, res_sh[WIDTH-1:1]};

  // Subtraction reuses the adder: A + ~B + 1.
  always_comb begin
    b_load = num_2;
    c_load = c;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_load = ~num_2;
      c_load = 1'b1;
    end
`else
    b_load = num_2;
    c_load = c;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // DONE accepts start just like IDLE so operations can run back to back.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      carry_ff <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      carry    <= 1'b0;
    end else if (load) begin
      a_sh     <= num_1;
      b_sh     <= b_load;
      res_sh   <= '0;
      carry_ff <= c_load;
      cnt      <= '0;
    end else if (step) begin
      a_sh     <= a_sh >> 1;
      b_sh     <= b_sh >> 1;
      res_sh   <= res_next;
      carry_ff <= fa_co;
      cnt      <= cnt + CW'(1);
      // Outputs only move on the completion edge so they hold the previous
      // result while a new operation is in flight.
      if (last) begin
        sum   <= res_next;
        carry <= fa_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_seq.sv
// tb/tb_serial_adder_seq.sv - self-checking bench for serial_adder_seq
module tb_serial_adder_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] num_1;
  logic [W-1:0] num_2;
  logic         c;
  logic         sub_r;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int exp_pulses = 0;
  int dbl = 0;
  logic prev_done = 1'b0;
  logic [W:0] last_res = '0;

  serial_adder_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .num_1 (num_1),
    .num_2 (num_2),
    .c     (c),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub_r),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        pulses = pulses + 1;
        if (prev_done) dbl = dbl + 1;
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] exp_sum;
    logic         exp_carry;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Arithmetic reference: {carry, sum} from plain integer math.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic ci, input logic sb);
    int unsigned ia, ib;
    ia = a;
    ib = b;
    if (sb) return {(ia >= ib), W'(ia - ib)};
    return (W+1)'(ia + ib + ci);
  endfunction

  // Called just after an edge; counts further edges until done is seen.
  task automatic wait_done(input logic [W:0] hold, output int edges,
                           output int busy_n, output int hold_bad);
    edges = 0;
    busy_n = 0;
    hold_bad = 0;
    @(negedge clk);
    while (!done && edges < 4 * W) begin
      if (busy) busy_n++;
      if ({carry, sum} !== hold) hold_bad++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic sb, input logic [W:0] exp);
    int e, bn, hb;
    @(negedge clk);
    num_1 = a; num_2 = b; c = ci; sub_r = sb; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    num_1 = W'($urandom); num_2 = W'($urandom); c = 1'($urandom); sub_r = 1'($urandom);
    wait_done(last_res, e, bn, hb);
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_latency"}, 32'(e), 32'(W));
    chk({name, "_busy_cycles"}, 32'(bn), 32'(W));
    chk({name, "_hold"}, 32'(hb), 32'd0);
    chk({name, "_busy_in_done"}, 32'(busy), 32'd0);
    chk({name, "_sum"}, 32'(sum), 32'(exp[W-1:0]));
    chk({name, "_carry"}, 32'(carry), 32'(exp[W]));
    exp_pulses++;
    last_res = exp;
  endtask

  initial begin
    int e, bn, hb;
    logic [W-1:0] ra, rb;
    logic rc, rs;
    logic [W:0] r1, r2, r3;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1};

    rst_n = 1'b0; start = 1'b0; num_1 = '0; num_2 = '0; c = 1'b0; sub_r = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0,
            {vecs[i].exp_carry, vecs[i].exp_sum});

    // start held high across three operations
    r1 = {1'b0, 8'h03}; r2 = {1'b0, 8'h30}; r3 = {1'b1, 8'h00};
    @(negedge clk);
    num_1 = 8'h01; num_2 = 8'h02; c = 1'b0; sub_r = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    wait_done(last_res, e, bn, hb);
    chk("b2b1_latency", 32'(e), 32'(W));
    chk("b2b1_hold", 32'(hb), 32'd0);
    chk("b2b1_res", 32'({carry, sum}), 32'(r1));
    num_1 = 8'h10; num_2 = 8'h20;
    @(posedge clk); #1;
    wait_done(r1, e, bn, hb);
    chk("b2b2_latency", 32'(e), 32'(W));
    chk("b2b2_hold", 32'(hb), 32'd0);
    chk("b2b2_res", 32'({carry, sum}), 32'(r2));
    num_1 = 8'h80; num_2 = 8'h80;
    @(posedge clk); #1;
    wait_done(r2, e, bn, hb);
    chk("b2b3_latency", 32'(e), 32'(W));
    chk("b2b3_hold", 32'(hb), 32'd0);
    chk("b2b3_res", 32'({carry, sum}), 32'(r3));
    start = 1'b0;
    exp_pulses += 3;
    last_res = r3;

    // start during RUN is ignored
    @(negedge clk);
    num_1 = 8'h12; num_2 = 8'h34; c = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    num_1 = 8'hAA; num_2 = 8'hAA; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(last_res, e, bn, hb);
    chk("ign_latency", 32'(e), 32'(W - 4));
    chk("ign_sum", 32'(sum), 32'h46);
    chk("ign_carry", 32'(carry), 32'd0);
    exp_pulses++;
    last_res = {1'b0, 8'h46};
    repeat (2 * W) @(negedge clk);
    chk("ign_idle", 32'(busy), 32'd0);

    // asynchronous reset in the middle of an operation
    do_op("pre_rst", 8'h21, 8'h10, 1'b1, 1'b0, {1'b0, 8'h32});
    @(negedge clk);
    num_1 = 8'h33; num_2 = 8'h44; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_sum", 32'(sum), 32'd0);
    chk("arst_carry", 32'(carry), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;
    repeat (2 * W) @(negedge clk);
    chk("arst_quiet", 32'(busy), 32'd0);
    do_op("post_rst", 8'h0F, 8'h01, 1'b0, 1'b0, {1'b0, 8'h10});

`ifdef SERIAL_ADDER_SUB_EN
    do_op("sub_borrow", 8'h05, 8'h07, 1'b1, 1'b1, {1'b0, 8'hFE});
    do_op("sub_noborrow", 8'h07, 8'h05, 1'b0, 1'b1, {1'b1, 8'h02});
`endif

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      do_op($sformatf("rnd%0d", i), ra, rb, rc, rs, model(ra, rb, rc, rs));
    end

    repeat (3) @(negedge clk);
    chk("done_pulses", 32'(pulses), 32'(exp_pulses));
    chk("done_width", 32'(dbl), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
